// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state encoding and defaults for the multiply/divide sequencer
package multdiv_pkg;
  localparam int COUNT_W = 6;
  localparam int DEF_MULT_CYCLES = 32;
  localparam int DEF_DIV_CYCLES = 32;
  typedef enum logic [2:0] {IDLE, MULT, DIV, DZERO, DONE} state_e;
endpackage

// File: rtl/iter_counter.sv
// iter_counter: saturating iteration counter with sync clear and terminal-count flag
module iter_counter
  import multdiv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [COUNT_W-1:0] limit,
  output logic [COUNT_W-1:0] count,
  output logic               tc
);
  logic [COUNT_W-1:0] count_q, count_d;
  // clear wins over enable; hold once the limit is reached
  always_comb begin
    count_d = clr ? '0 : (en && count_q != limit) ? count_q + 1'b1 : count_q;
  end
  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  end
  assign count = count_q;
  assign tc = count_q == limit;
endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences the iterative multiplier/divider and captures their results
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ctrl_MULT,
  input  logic               ctrl_DIV,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  input  logic [WIDTH-1:0]   mult_result,
  input  logic               mult_overflow,
  input  logic [WIDTH-1:0]   div_result,
  output logic [WIDTH-1:0]   dp_opA,
  output logic [WIDTH-1:0]   dp_opB,
  output logic [COUNT_W-1:0] dp_count,
  output logic               dp_sel_div,
  output logic               busy,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_exception,
  output logic               data_resultRDY
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic sel_div_q, sel_div_d, exc_q, exc_d;
  logic start, tc;
  logic [COUNT_W-1:0] limit;
  assign start = ctrl_MULT | ctrl_DIV;
  assign limit = sel_div_q ? COUNT_W'(DIV_CYCLES) : COUNT_W'(MULT_CYCLES);
  iter_counter u_cnt (
    .clk  (clk),
    .rst_n(reset_n),
    .clr  (start),
    .en   (state_q == MULT || state_q == DIV),
    .limit(limit),
    .count(dp_count),
    .tc   (tc)
  );
  // next state and capture; a start pulse aborts any operation without capturing
  always_comb begin
    state_d = state_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    sel_div_d = sel_div_q;
    result_d = result_q;
    exc_d = exc_q;
    if (start) begin
      op_a_d = data_operandA;
      op_b_d = data_operandB;
      sel_div_d = !ctrl_MULT;
      state_d = ctrl_MULT ? MULT : (data_operandB != '0) ? DIV : DZERO;
    end else begin
      case (state_q)
        MULT: if (tc) begin
          result_d = mult_result;
          exc_d = mult_overflow;
          state_d = DONE;
        end
        DIV: if (tc) begin
          result_d = div_result;
          exc_d = 1'b0;
          state_d = DONE;
        end
        DZERO: begin
          result_d = '0;
          exc_d = 1'b1;
          state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end
  // state, operand and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_a_q <= '0;
      op_b_q <= '0;
      sel_div_q <= 1'b0;
      result_q <= '0;
      exc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      sel_div_q <= sel_div_d;
      result_q <= result_d;
      exc_q <= exc_d;
    end
  end
  assign dp_opA = op_a_q;
  assign dp_opB = op_b_q;
  assign dp_sel_div = sel_div_q;
  assign busy = state_q == MULT || state_q == DIV || state_q == DZERO;
  assign data_result = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = state_q == DONE;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: vector table plus scoreboard checks of the multiply/divide sequencer
module tb_multdiv_ctrl;
  logic clk = 0, reset_n = 0, ctrl_MULT = 0, ctrl_DIV = 0;
  logic [31:0] a = 0, b = 0, mult_result, div_result, dp_opA, dp_opB, data_result;
  logic mult_overflow, dp_sel_div, busy, data_exception, data_resultRDY;
  logic [5:0] dp_count;
  logic signed [63:0] prod;

  typedef struct {logic is_div; logic [31:0] a, b, res; logic exc; int lat;} vec_t;
  typedef struct packed {logic [31:0] res; logic exc; logic sel;} exp_t;
  vec_t vecs[6];
  exp_t sbq[$];
  exp_t mon_e;
  int n_vec = 0, n_err = 0;

  multdiv_ctrl dut (
    .clk(clk), .reset_n(reset_n), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(a), .data_operandB(b), .mult_result(mult_result),
    .mult_overflow(mult_overflow), .div_result(div_result), .dp_opA(dp_opA),
    .dp_opB(dp_opB), .dp_count(dp_count), .dp_sel_div(dp_sel_div), .busy(busy),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clk = ~clk;

  // behavioural stand-in for the two datapaths, fed from the latched operands
  always_comb begin
    prod = $signed({{32{dp_opA[31]}}, dp_opA}) * $signed({{32{dp_opB[31]}}, dp_opB});
    mult_result = prod[31:0];
    mult_overflow = prod != {{32{prod[31]}}, prod[31:0]};
    div_result = '0;
    if (dp_opB != 0) div_result = $signed(dp_opA) / $signed(dp_opB);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start(input logic m, input logic d, input logic [31:0] oa, input logic [31:0] ob);
    @(posedge clk); #1;
    ctrl_MULT = m; ctrl_DIV = d; a = oa; b = ob;
    @(posedge clk); #1;
    ctrl_MULT = 0; ctrl_DIV = 0;
  endtask

  task automatic wait_rdy(input string name, input int exp_lat);
    int lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
    chk(name, 32'(lat), 32'(exp_lat));
  endtask

  task automatic wait_count(input logic [5:0] target);
    int k = 0;
    while (dp_count != target && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_count", 32'(dp_count), 32'(target));
  endtask

  // scoreboard: every RDY pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (reset_n && data_resultRDY) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rdy: got RDY=1 expected 0");
      end else begin
        mon_e = sbq.pop_front();
        chk("result", data_result, mon_e.res);
        chk("exception", 32'(data_exception), 32'(mon_e.exc));
        chk("sel_div", 32'(dp_sel_div), 32'(mon_e.sel));
        chk("busy_in_rdy", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    vecs[0] = '{1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33};
    vecs[1] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 33};
    vecs[2] = '{1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 33};
    vecs[3] = '{1'b1, 32'd5, 32'd0, 32'd0, 1'b1, 1};
    vecs[4] = '{1'b0, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd25, 1'b0, 33};
    vecs[5] = '{1'b1, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 1'b0, 33};
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdy", 32'(data_resultRDY), 0);
    chk("rst_count", 32'(dp_count), 0);
    chk("rst_result", data_result, 0);
    chk("rst_exc", 32'(data_exception), 0);
    @(negedge clk) reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      sbq.push_back('{res: vecs[i].res, exc: vecs[i].exc, sel: vecs[i].is_div});
      start(!vecs[i].is_div, vecs[i].is_div, vecs[i].a, vecs[i].b);
      chk("busy_after_start", 32'(busy), 1);
      chk("count_after_start", 32'(dp_count), 0);
      chk("sel_after_start", 32'(dp_sel_div), 32'(vecs[i].is_div));
      wait_rdy("latency", vecs[i].lat);
      repeat (3) @(posedge clk);
      #1 chk("result_held", data_result, vecs[i].res);
    end
    sbq.push_back('{res: 32'd3, exc: 1'b0, sel: 1'b1});
    start(1, 0, 32'd2, 32'd3);
    wait_count(6'd10);
    ctrl_DIV = 1; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    ctrl_DIV = 0;
    chk("restart_count", 32'(dp_count), 0);
    chk("restart_sel", 32'(dp_sel_div), 1);
    wait_rdy("restart_latency", 33);
    repeat (40) @(posedge clk);
    start(1, 0, 32'd5, 32'd5);
    wait_count(6'd15);
    #3 reset_n = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rdy", 32'(data_resultRDY), 0);
    chk("arst_count", 32'(dp_count), 0);
    chk("arst_opA", dp_opA, 0);
    chk("arst_opB", dp_opB, 0);
    chk("arst_result", data_result, 0);
    chk("arst_exc", 32'(data_exception), 0);
    chk("arst_sel", 32'(dp_sel_div), 0);
    @(negedge clk) reset_n = 1;
    repeat (40) @(posedge clk);
    #1 chk("idle_after_reset", 32'(busy), 0);
    sbq.push_back('{res: 32'd0, exc: 1'b1, sel: 1'b1});
    sbq.push_back('{res: 32'd20, exc: 1'b0, sel: 1'b0});
    start(0, 1, 32'd5, 32'd0);
    @(posedge clk); #1;
    chk("dz_rdy", 32'(data_resultRDY), 1);
    ctrl_MULT = 1; a = 32'd4; b = 32'd5;
    @(posedge clk); #1;
    ctrl_MULT = 0;
    chk("done_start_busy", 32'(busy), 1);
    chk("done_start_count", 32'(dp_count), 0);
    wait_rdy("done_start_latency", 33);
    sbq.push_back('{res: 32'd12, exc: 1'b0, sel: 1'b0});
    start(1, 1, 32'd6, 32'd2);
    chk("both_sel", 32'(dp_sel_div), 0);
    wait_rdy("both_latency", 33);
    repeat (5) @(posedge clk);
    #1 chk("scoreboard_empty", 32'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
